// File: rtl/crossing_pkg.sv
// rtl/crossing_pkg.sv - shared state type, timing defaults and counter helper for the crossing controller
//
// Purpose: common definitions imported by multi_track_crossing_ctrl and track_occ_counter.
// Contents: state_t (controller states), DEF_* default parameters, sat_next() saturating count step.
package crossing_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WARN   = 3'd1,
        CLOSED = 3'd2,
        HOLD   = 3'd3,
        FAULT  = 3'd4
    } state_t;

    localparam int DEF_NUM_TRACKS   = 2;
    localparam int DEF_CNT_W        = 3;
    localparam int DEF_TMR_W        = 8;
    localparam int DEF_WARN_CYCLES  = 4;
    localparam int DEF_CLEAR_CYCLES = 6;
    localparam int DEF_FAULT_CYCLES = 200;

    // Next occupancy count: +1 on an arrival, -1 on an exit, unchanged when both
    // or neither occur. Saturates at 0 and max_val instead of wrapping.
    function automatic int sat_next(input int count, input int max_val,
                                    input logic inc, input logic dec);
        int nxt;
        nxt = count;
        if (inc && !dec && count < max_val) begin
            nxt = count + 1;
        end else if (dec && !inc && count > 0) begin
            nxt = count - 1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/track_occ_counter.sv
// rtl/track_occ_counter.sv - per-track sensor edge detect and saturating occupancy counter
//
// Purpose: counts trains between approach sensor A and exit sensor B of one track.
// Optional macro: CROSSING_STATS_EN adds the dec_ok output.
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   sensor_a/b       synchronised level sensors
//   clear            forces the count to 0 and suppresses ovf/unf this cycle
//   count            current occupancy
//   ovf / unf        combinational: this edge would overflow / underflow (count held)
//   dec_ok           combinational: this edge performs a real decrement (stats build)
module track_occ_counter
    import crossing_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sensor_a,
    input  logic             sensor_b,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic             ovf,
    output logic             unf
`ifdef CROSSING_STATS_EN
    ,
    output logic             dec_ok
`endif
);

    localparam int MAX_VAL = (1 << CNT_W) - 1;

    logic prev_a;
    logic prev_b;
    logic rise_a;
    logic rise_b;

    assign rise_a = sensor_a & ~prev_a;
    assign rise_b = sensor_b & ~prev_b;

    assign ovf = rise_a & ~rise_b & (count == CNT_W'(MAX_VAL)) & ~clear;
    assign unf = rise_b & ~rise_a & (count == '0) & ~clear;

`ifdef CROSSING_STATS_EN
    assign dec_ok = rise_b & ~rise_a & (count != '0) & ~clear;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_a <= 1'b0;
            prev_b <= 1'b0;
            count  <= '0;
        end else begin
            prev_a <= sensor_a;
            prev_b <= sensor_b;
            if (clear) begin
                count <= '0;
            end else begin
                count <= CNT_W'(sat_next(int'(count), MAX_VAL, rise_a, rise_b));
            end
        end
    end

endmodule

// File: rtl/multi_track_crossing_ctrl.sv
// rtl/multi_track_crossing_ctrl.sv - multi-track level crossing controller with warning, clearance and fault
//
// Purpose: drives gate and road signal from per-track occupancy with timed WARN and HOLD phases.
// Optional macro: CROSSING_STATS_EN adds train_total and fault_cnt outputs.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   sensor_a, sensor_b    per-track approach / exit sensors (synchronised levels)
//   fault_clr             operator acknowledge, only honoured in FAULT
//   gate_down, signal_red, lamp_flash, fault   registered Moore outputs
//   occupied              per-track nonzero-count flags
//   train_total, fault_cnt  statistics (stats build only)
module multi_track_crossing_ctrl
    import crossing_pkg::*;
#(
    parameter int NUM_TRACKS   = DEF_NUM_TRACKS,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int TMR_W        = DEF_TMR_W,
    parameter int WARN_CYCLES  = DEF_WARN_CYCLES,
    parameter int CLEAR_CYCLES = DEF_CLEAR_CYCLES,
    parameter int FAULT_CYCLES = DEF_FAULT_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_TRACKS-1:0] sensor_a,
    input  logic [NUM_TRACKS-1:0] sensor_b,
    input  logic                  fault_clr,
    output logic                  gate_down,
    output logic                  signal_red,
    output logic                  lamp_flash,
    output logic                  fault,
    output logic [NUM_TRACKS-1:0] occupied
`ifdef CROSSING_STATS_EN
    ,
    output logic [15:0]           train_total,
    output logic [7:0]            fault_cnt
`endif
);

    localparam logic [TMR_W-1:0] WARN_LAST  = TMR_W'(WARN_CYCLES - 1);
    localparam logic [TMR_W-1:0] CLEAR_LAST = TMR_W'(CLEAR_CYCLES - 1);
    localparam logic [TMR_W-1:0] FAULT_LAST = TMR_W'(FAULT_CYCLES - 1);

    state_t                  state;
    state_t                  nxt_state;
    logic [TMR_W-1:0]        timer;
    logic [TMR_W-1:0]        nxt_timer;
    logic [CNT_W-1:0]        count [NUM_TRACKS];
    logic [NUM_TRACKS-1:0]   ovf_v;
    logic [NUM_TRACKS-1:0]   unf_v;
    logic                    any_occ;
    logic                    cnt_err;
    logic                    clear_cnt;
`ifdef CROSSING_STATS_EN
    logic [NUM_TRACKS-1:0]   dec_v;
`endif

    // Counters are wiped only on the edge that leaves FAULT.
    assign clear_cnt = (state == FAULT) && fault_clr;

    for (genvar i = 0; i < NUM_TRACKS; i++) begin : g_track
        track_occ_counter #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .clk     (clk),
            .reset   (reset),
            .sensor_a(sensor_a[i]),
            .sensor_b(sensor_b[i]),
            .clear   (clear_cnt),
            .count   (count[i]),
            .ovf     (ovf_v[i]),
            .unf     (unf_v[i])
`ifdef CROSSING_STATS_EN
            ,
            .dec_ok  (dec_v[i])
`endif
        );
        assign occupied[i] = (count[i] != '0);
    end

    assign any_occ = |occupied;
    assign cnt_err = |ovf_v | |unf_v;

    always_comb begin
        nxt_state = state;
        nxt_timer = timer + TMR_W'(1);
        case (state)
            IDLE: begin
                if (any_occ) nxt_state = WARN;
            end
            WARN: begin
                if (timer == WARN_LAST) nxt_state = CLOSED;
            end
            CLOSED: begin
                if (!any_occ)                nxt_state = HOLD;
                else if (timer == FAULT_LAST) nxt_state = FAULT;
            end
            HOLD: begin
                if (any_occ)                  nxt_state = CLOSED;
                else if (timer == CLEAR_LAST) nxt_state = IDLE;
            end
            FAULT: begin
                if (fault_clr) nxt_state = HOLD;
            end
            default: nxt_state = FAULT;
        endcase
        if (cnt_err) nxt_state = FAULT;
        // Timer restarts whenever the phase changes; it only matters in WARN/CLOSED/HOLD.
        if (nxt_state != state || state == IDLE || state == FAULT) nxt_timer = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            timer      <= '0;
            gate_down  <= 1'b0;
            signal_red <= 1'b0;
            lamp_flash <= 1'b0;
            fault      <= 1'b0;
        end else begin
            state      <= nxt_state;
            timer      <= nxt_timer;
            gate_down  <= (nxt_state == CLOSED) || (nxt_state == HOLD) || (nxt_state == FAULT);
            signal_red <= (nxt_state != IDLE);
            fault      <= (nxt_state == FAULT);
            // Lamp starts lit on WARN entry, then alternates through CLOSED and HOLD.
            case (nxt_state)
                WARN:         lamp_flash <= (state == WARN) ? ~lamp_flash : 1'b1;
                CLOSED, HOLD: lamp_flash <= ~lamp_flash;
                FAULT:        lamp_flash <= 1'b1;
                default:      lamp_flash <= 1'b0;
            endcase
        end
    end

`ifdef CROSSING_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            train_total <= '0;
            fault_cnt   <= '0;
        end else begin
            train_total <= train_total + 16'($countones(dec_v));
            if (nxt_state == FAULT && state != FAULT && fault_cnt != 8'hFF) begin
                fault_cnt <= fault_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_multi_track_crossing_ctrl.sv
// tb/tb_multi_track_crossing_ctrl.sv - randomized and directed bench with behavioural crossing model
module tb_multi_track_crossing_ctrl;

    localparam int NT    = 2;
    localparam int CW    = 3;
    localparam int WARNC = 4;
    localparam int CLRC  = 6;
    localparam int FLTC  = 200;
    localparam int MAXC  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NT-1:0] sensor_a = '0;
    logic [NT-1:0] sensor_b = '0;
    logic          fault_clr = 1'b0;
    logic          gate_down;
    logic          signal_red;
    logic          lamp_flash;
    logic          fault;
    logic [NT-1:0] occupied;
`ifdef CROSSING_STATS_EN
    logic [15:0]   train_total;
    logic [7:0]    fault_cnt;
`endif

    int errors = 0;
    int checks = 0;

    multi_track_crossing_ctrl #(
        .NUM_TRACKS  (NT),
        .CNT_W       (CW),
        .TMR_W       (8),
        .WARN_CYCLES (WARNC),
        .CLEAR_CYCLES(CLRC),
        .FAULT_CYCLES(FLTC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sensor_a  (sensor_a),
        .sensor_b  (sensor_b),
        .fault_clr (fault_clr),
        .gate_down (gate_down),
        .signal_red(signal_red),
        .lamp_flash(lamp_flash),
        .fault     (fault),
        .occupied  (occupied)
`ifdef CROSSING_STATS_EN
        ,
        .train_total(train_total),
        .fault_cnt  (fault_cnt)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 warning, 2 closed, 3 clearance hold, 4 fault
    int          mcnt [NT];
    logic [NT-1:0] mpa = '0;
    logic [NT-1:0] mpb = '0;
    int          mphase = 0;
    int          mspent = 0;   // cycles already spent in the current phase
    bit          mlamp = 0;
`ifdef CROSSING_STATS_EN
    int          mtot = 0;
    int          mfcnt = 0;
`endif

    initial begin
        for (int i = 0; i < NT; i++) mcnt[i] = 0;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                for (int i = 0; i < NT; i++) mcnt[i] = 0;
                mpa = '0; mpb = '0; mphase = 0; mspent = 0; mlamp = 0;
`ifdef CROSSING_STATS_EN
                mtot = 0; mfcnt = 0;
`endif
            end else begin
                bit any;
                bit err;
                bit clr;
                int np;
                any = 0;
                for (int i = 0; i < NT; i++) if (mcnt[i] != 0) any = 1;
                clr = (mphase == 4) && fault_clr;
                err = 0;
                for (int i = 0; i < NT; i++) begin
                    bit ra;
                    bit rb;
                    ra = sensor_a[i] && !mpa[i];
                    rb = sensor_b[i] && !mpb[i];
                    if (clr) mcnt[i] = 0;
                    else if (ra && !rb) begin
                        if (mcnt[i] == MAXC) err = 1; else mcnt[i]++;
                    end else if (rb && !ra) begin
                        if (mcnt[i] == 0) err = 1;
                        else begin
                            mcnt[i]--;
`ifdef CROSSING_STATS_EN
                            mtot = (mtot + 1) % 65536;
`endif
                        end
                    end
                end
                mpa = sensor_a;
                mpb = sensor_b;
                np = mphase;
                case (mphase)
                    0: if (any) np = 1;
                    1: if (mspent + 1 >= WARNC) np = 2;
                    2: if (!any) np = 3; else if (mspent + 1 >= FLTC) np = 4;
                    3: if (any) np = 2; else if (mspent + 1 >= CLRC) np = 0;
                    default: if (fault_clr) np = 3;
                endcase
                if (err) np = 4;
                if (np == 1 && mphase != 1) mlamp = 1;
                else if (np >= 1 && np <= 3) mlamp = !mlamp;
                else mlamp = (np == 4);
`ifdef CROSSING_STATS_EN
                if (np == 4 && mphase != 4 && mfcnt < 255) mfcnt++;
`endif
                mspent = (np == mphase) ? mspent + 1 : 0;
                mphase = np;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // One compare per negedge against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                logic [3:0]    ectl;
                logic [NT-1:0] eocc;
                ectl = {(mphase >= 2), (mphase != 0), mlamp, (mphase == 4)};
                for (int i = 0; i < NT; i++) eocc[i] = (mcnt[i] != 0);
                check("model_ctrl", {28'd0, gate_down, signal_red, lamp_flash, fault}, {28'd0, ectl});
                check("model_occ", 32'(occupied), 32'(eocc));
`ifdef CROSSING_STATS_EN
                check("model_total", 32'(train_total), 32'(mtot));
                check("model_fcnt", 32'(fault_cnt), 32'(mfcnt));
`endif
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic pulse_a(input int i);
        sensor_a[i] = 1'b1; cyc(1); sensor_a[i] = 1'b0;
    endtask

    task automatic pulse_b(input int i);
        sensor_b[i] = 1'b1; cyc(1); sensor_b[i] = 1'b0;
    endtask

    task automatic clear_fault();
        fault_clr = 1'b1; cyc(1); fault_clr = 1'b0; cyc(CLRC + 2);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(3);
        check("reset_outputs", {27'd0, gate_down, signal_red, lamp_flash, fault, 1'b0} | 32'(occupied), 32'd0);
        reset = 1'b0;
        cyc(2);

        // Single train on track 0.
        pulse_a(0);
        check("t1_occ", 32'(occupied), 32'b01);
        check("t1_red_latency", 32'(signal_red), 32'd0);
        cyc(1);
        check("t1_warn", {29'd0, gate_down, signal_red, lamp_flash}, 32'b011);
        cyc(3);
        check("t1_warn_last_gate", 32'(gate_down), 32'd0);
        cyc(1);
        check("t1_closed_gate", 32'(gate_down), 32'd1);
        cyc(14);
        pulse_b(0);
        check("t1_exit_occ", 32'(occupied), 32'd0);
        cyc(6);
        check("t1_hold_gate", 32'(gate_down), 32'd1);
        cyc(1);
        check("t1_idle", {28'd0, gate_down, signal_red, lamp_flash, fault}, 32'd0);
        cyc(3);

        // Overlapping trains on tracks 0 and 1.
        pulse_a(0); cyc(3);
        pulse_a(1); cyc(8);
        pulse_b(0); cyc(10);
        check("ovl_gate_held", 32'(gate_down), 32'd1);
        pulse_b(1); cyc(6);
        check("ovl_hold_gate", 32'(gate_down), 32'd1);
        cyc(1);
        check("ovl_idle_gate", 32'(gate_down), 32'd0);
        cyc(3);

        // Re-arrival during HOLD.
        pulse_a(1); cyc(10);
        pulse_b(1); cyc(3);
        pulse_a(1);
        check("rearr_gate", 32'(gate_down), 32'd1);
        cyc(5);
        pulse_b(1); cyc(6);
        check("rearr_hold_gate", 32'(gate_down), 32'd1);
        cyc(1);
        check("rearr_idle_gate", 32'(gate_down), 32'd0);
        cyc(3);

        // Underflow from idle.
        pulse_b(0);
        check("unf_fault", {30'd0, fault, gate_down}, 32'b11);
        cyc(2);
        fault_clr = 1'b1; cyc(1); fault_clr = 1'b0;
        check("unf_clr_hold", {29'd0, fault, gate_down, occupied[0]}, 32'b010);
        cyc(5);
        check("unf_hold_gate", 32'(gate_down), 32'd1);
        cyc(1);
        check("unf_idle", {30'd0, gate_down, signal_red}, 32'd0);
        cyc(3);

        // Occupancy timeout.
        pulse_a(0);
        cyc(204);
        check("tmo_before", {30'd0, fault, gate_down}, 32'b01);
        cyc(1);
        check("tmo_fault", 32'(fault), 32'd1);
        fault_clr = 1'b1; cyc(1); fault_clr = 1'b0;
        check("tmo_clr_occ", 32'(occupied), 32'd0);
        cyc(CLRC + 2);

        // Simultaneous A and B rise.
        sensor_a[1] = 1'b1; sensor_b[1] = 1'b1; cyc(1);
        sensor_a[1] = 1'b0; sensor_b[1] = 1'b0; cyc(2);
        check("simul_quiet", {29'd0, occupied[1], fault, signal_red}, 32'd0);

        // Overflow on track 0.
        for (int k = 0; k < MAXC; k++) begin pulse_a(0); cyc(1); end
        check("ovf_prefault", 32'(fault), 32'd0);
        pulse_a(0);
        check("ovf_fault", {30'd0, fault, occupied[0]}, 32'b11);
        clear_fault();

        // Asynchronous reset in CLOSED.
        pulse_a(1); cyc(8);
        check("rst_pre_gate", 32'(gate_down), 32'd1);
        reset = 1'b1; #1;
        check("rst_async", {27'd0, gate_down, signal_red, lamp_flash, fault, 1'b0} | 32'(occupied), 32'd0);
        cyc(2);
        reset = 1'b0;
        cyc(2);

`ifdef CROSSING_STATS_EN
        for (int k = 0; k < 3; k++) begin
            pulse_a(0); cyc(3); pulse_b(0); cyc(2);
        end
        check("stats_three_trains", 32'(train_total), 32'd3);
`endif

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NT; i++) begin
                sensor_a[i] = ($urandom_range(0, 6) == 0);
                sensor_b[i] = ($urandom_range(0, 8) == 0);
            end
            fault_clr = ($urandom_range(0, 3) == 0);
            cyc(1);
        end
        sensor_a = '0; sensor_b = '0; fault_clr = 1'b1;
        cyc(2);
        fault_clr = 1'b0;
        cyc(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multi_track_crossing_ctrl.md
Name: multi_track_crossing_ctrl

Overview:
- Parametrised crossing controller for NUM_TRACKS parallel tracks. Each track has an approach sensor A and an exit sensor B, and a per-track counter tracks how many trains are between them.
- Adds three things over the single-track controller: a timed pre-close warning phase, a timed clearance hold before reopening, and a fail-safe fault state.
- Sits between the trackside sensor synchronisers and the gate actuator / road signal drivers.

Parameters:
- NUM_TRACKS, 2, number of tracks (1..8).
- CNT_W, 3, width of each per-track occupancy counter; saturates at 2^CNT_W-1.
- TMR_W, 8, width of the shared phase timer.
- WARN_CYCLES, 4, cycles of warning (red signal, gate still up) before the gate lowers; 1..2^TMR_W-1.
- CLEAR_CYCLES, 6, cycles the crossing must stay empty before the gate lifts; 1..2^TMR_W-1.
- FAULT_CYCLES, 200, maximum cycles of continuous CLOSED occupancy before a fault; 1..2^TMR_W-1.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- sensor_a  in  NUM_TRACKS  approach sensors, already synchronised, level.
- sensor_b  in  NUM_TRACKS  exit sensors, already synchronised, level.
- fault_clr  in  1  operator fault acknowledge; level, sampled only in FAULT.
- gate_down  out  1  1 = command the gate down.
- signal_red  out  1  1 = road signal red.
- lamp_flash  out  1  warning lamp drive.
- fault  out  1  1 = controller is in FAULT.
- occupied  out  NUM_TRACKS  bit i = 1 when track i's count is nonzero.

Behaviour:
- Reset (async): state=IDLE, counters=0, timer=0, sensor history=0. All outputs are 0.
- Edge detect: rise_x[i] = sensor_x[i] & ~prev_x[i]; prev_x is registered each cycle. A sensor held high counts once only.
- Counter update per track, on each clk edge:
  - rise_a only → +1.
  - rise_b only → −1.
  - Both rises in the same cycle → no change.
  - +1 at max → hold the value and raise ovf.
  - −1 at 0 → hold 0 and raise unf.
- any_occ = OR of occupied.
- Latency: the edge that first samples sensor_a high sets the count. The next edge moves IDLE→WARN.
- FSM (Moore outputs; timer cleared on every state change):
  - IDLE: any_occ → WARN.
  - WARN: timer counts up. When timer==WARN_CYCLES-1 → CLOSED. Further arrivals do not restart WARN.
  - CLOSED: timer counts while any_occ. If timer reaches FAULT_CYCLES-1 → FAULT. When any_occ=0 → HOLD.
  - HOLD: any_occ → CLOSED, with the timer restarted. Otherwise, when timer==CLEAR_CYCLES-1 → IDLE.
  - FAULT: stays until fault_clr=1. Then all counters clear to 0 and the next state is HOLD, so the gate reopens only after clearance.
  - Any state: ovf or unf → FAULT, with priority over every other transition.
- Outputs by state:
  - gate_down=1 in CLOSED, HOLD, FAULT.
  - signal_red=1 in WARN, CLOSED, HOLD, FAULT.
  - lamp_flash toggles every cycle in WARN, CLOSED and HOLD, starting at 1 on entry to WARN. It is constant 1 in FAULT and 0 in IDLE.
  - fault=1 only in FAULT.
- Counters keep updating in all states except on the clearing edge in FAULT.
- The gate never rises directly from CLOSED or FAULT; HOLD is always traversed.
- Illegal state encoding → FAULT.

Optional Feature:
- CROSSING_STATS_EN:
  - Defined: adds output train_total [15:0], reset 0. It increments once per accepted rise_b, i.e. a decrement that is not an underflow, summed over tracks per cycle, and wraps at 2^16.
  - Also adds fault_cnt [7:0], which increments on each entry to FAULT and saturates at 255.
  - Undefined: neither port nor its logic exists.

Decomposition:
- Package crossing_pkg holds:
  - The state enum IDLE, WARN, CLOSED, HOLD, FAULT.
  - Default timing constants.
  - A function computing the saturating next count.
- One sub-module, track_occ_counter: edge detect, saturating up/down counter, ovf/unf for a single track. It is instantiated NUM_TRACKS times with generate.

Test Plan:
- Single train, track 0: A pulse, then B pulse 20 cycles later → WARN 4 cycles, gate_down 1 cycle after the count returns to 0 plus CLEAR_CYCLES, then IDLE with all outputs 0.
- Overlap: track 0 A, then track 1 A, then track 0 B → gate stays down until track 1 B, then HOLD 6 cycles → IDLE.
- Re-arrival in HOLD: track 1 A pulse at HOLD cycle 3 → back to CLOSED, gate_down never drops, new HOLD of 6 full cycles after the exit.
- Underflow: B pulse on an idle track → fault=1, gate_down=1 the next cycle. fault_clr → counts 0, HOLD 6 cycles → IDLE.
- Timeout: A without B for 200 CLOSED cycles → FAULT. Simultaneous A and B rise on one track → count unchanged, no fault.
- Reset asserted mid-CLOSED → outputs 0 immediately (async), counters 0. CROSSING_STATS_EN build: 3 trains → train_total=3.
